// File: rtl/shift_deser_rx.sv
// Serial-to-parallel receiver: assembles framed WIDTH-bit words (LSB- or MSB-first)
// into a one-deep valid/ready holding register. Optional macro: SHIFT_DESER_PARITY_CHECK_EN.
module shift_deser_rx #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sdata,
  input  logic             sframe,
  input  logic             msb_first,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             frame_err,
  output logic             overrun,
  output logic             parity_err
);

`ifdef SHIFT_DESER_PARITY_CHECK_EN
  localparam int unsigned FRAME_LEN = WIDTH + 1;
`else
  localparam int unsigned FRAME_LEN = WIDTH;
`endif
  localparam int unsigned    CW       = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0]  LAST_IDX = CW'(FRAME_LEN - 1);

  typedef enum logic {IDLE, RECV} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             msb_q, msb_d;
  logic             out_valid_q, out_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic [WIDTH-1:0] shifted, word;
  logic             done;
`ifdef SHIFT_DESER_PARITY_CHECK_EN
  logic             parity_err_q, parity_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    msb_d       = msb_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    done        = 1'b0;
`ifdef SHIFT_DESER_PARITY_CHECK_EN
    parity_err_d = 1'b0;
`endif

    shifted = msb_q ? {sr_q[WIDTH-2:0], sdata} : {sdata, sr_q[WIDTH-1:1]};
`ifdef SHIFT_DESER_PARITY_CHECK_EN
    // The final bit is parity only; the data word is already complete in sr_q.
    word = sr_q;
`else
    word = shifted;
`endif

    if (out_valid_q && out_ready)
      out_valid_d = 1'b0;

    // A qualified frame marker always starts a new word, aborting any partial one.
    if (en && sframe) begin
      frame_err_d = (state_q == RECV);
      state_d     = RECV;
      cnt_d       = CW'(1);
      msb_d       = msb_first;
      sr_d        = msb_first ? {{(WIDTH-1){1'b0}}, sdata} : {sdata, {(WIDTH-1){1'b0}}};
    end else if (state_q == RECV && en) begin
      cnt_d = cnt_q + CW'(1);
      sr_d  = shifted;
      done  = (cnt_q == LAST_IDX);
    end

    if (done) begin
      state_d = IDLE;
      cnt_d   = '0;
`ifdef SHIFT_DESER_PARITY_CHECK_EN
      parity_err_d = ^{sr_q, sdata};
`endif
      if (!out_valid_q || out_ready) begin
        out_data_d  = word;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sr_q        <= '0;
      msb_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef SHIFT_DESER_PARITY_CHECK_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      msb_q       <= msb_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef SHIFT_DESER_PARITY_CHECK_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef SHIFT_DESER_PARITY_CHECK_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_shift_deser_rx.sv
// Directed bench for shift_deser_rx: expected words queued as frames are sent,
// popped and compared at each valid/ready transfer.
module tb_shift_deser_rx;
  localparam int unsigned WIDTH = 4;
`ifdef SHIFT_DESER_PARITY_CHECK_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             en = 1'b0, sdata = 1'b0, sframe = 1'b0, msb_first = 1'b0, out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_valid, frame_err, overrun, parity_err;

  int checks = 0;
  int errors = 0;
  int fe_seen = 0, ov_seen = 0, pe_seen = 0;
  logic [WIDTH-1:0] exp_q[$];

  shift_deser_rx #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .en(en), .sdata(sdata), .sframe(sframe),
    .msb_first(msb_first), .out_ready(out_ready), .out_data(out_data),
    .out_valid(out_valid), .frame_err(frame_err), .overrun(overrun),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle; a transfer that will occur on this edge is scored before it.
  task automatic step(input logic e, input logic sf, input logic d, input logic rdy);
    logic [WIDTH-1:0] expw;
    en = e; sframe = sf; sdata = d; out_ready = rdy;
    #1;
    if (out_valid === 1'b1 && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_transfer", 32'(out_data), 32'hFFFF_FFFF);
      end else begin
        expw = exp_q.pop_front();
        chk("word", 32'(out_data), 32'(expw));
      end
    end
    @(posedge clk);
    #1;
    fe_seen += int'(frame_err);
    ov_seen += int'(overrun);
    pe_seen += int'(parity_err);
  endtask

  function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] seq, input logic msb);
    logic [WIDTH-1:0] r;
    for (int unsigned i = 0; i < WIDTH; i++) r[i] = seq[WIDTH-1-i];
    return msb ? seq : r;
  endfunction

  // seq[WIDTH-1] is sent first; out_ready is raised only on the final frame bit.
  task automatic send_word(input logic [WIDTH-1:0] seq, input logic msb, input logic rdy_last,
                           input logic bad_par);
    msb_first = msb;
    for (int i = WIDTH - 1; i >= 0; i--)
      step(1'b1, i == WIDTH - 1, seq[i], (i == 0 && !PAR) ? rdy_last : 1'b0);
    if (PAR) step(1'b1, 1'b0, ^seq ^ bad_par, rdy_last);
  endtask

  task automatic drain();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("drained_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [WIDTH-1:0] rw;
    logic             rm;
    @(posedge clk); #1;
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_data", 32'(out_data), 32'd0);
    chk("reset_pulses", {29'd0, frame_err, overrun, parity_err}, 32'd0);
    reset = 1'b0;

    // MSB-first, then LSB-first on the same bit sequence
    exp_q.push_back(model(4'b1011, 1'b1));
    send_word(4'b1011, 1'b1, 1'b0, 1'b0);
    chk("valid_after_last_bit", 32'(out_valid), 32'd1);
    drain();
    exp_q.push_back(4'b1101);
    send_word(4'b1011, 1'b0, 1'b0, 1'b0);
    chk("valid_lsb_first", 32'(out_valid), 32'd1);
    drain();

    // en=0 gaps with toggling inputs must be ignored
    msb_first = 1'b1;
    exp_q.push_back(4'b1011);
    step(1, 1, 1, 0); step(1, 0, 0, 0);
    step(0, 1, 0, 0); step(0, 0, 1, 0); step(0, 1, 1, 0);
    step(1, 0, 1, 0);
    if (PAR) begin step(1, 0, 1, 0); step(1, 0, 1, 0); end
    else step(1, 0, 1, 0);
    chk("gap_valid", 32'(out_valid), 32'd1);
    chk("gap_no_frame_err", 32'(fe_seen), 32'd0);
    drain();

    // Resync mid-word
    step(1, 1, 1, 0); step(1, 0, 1, 0);
    step(1, 1, 0, 0);
    chk("resync_frame_err", 32'(frame_err), 32'd1);
    step(1, 0, 1, 0);
    chk("frame_err_one_cycle", 32'(frame_err), 32'd0);
    step(1, 0, 1, 0);
    exp_q.push_back(4'b0110);
    step(1, 0, 0, 0);
    if (PAR) step(1, 0, 0, 0);
    chk("resync_valid", 32'(out_valid), 32'd1);
    drain();
    chk("frame_err_total", 32'(fe_seen), 32'd1);

    // Overrun: second back-to-back word dropped while holding register full
    exp_q.push_back(4'b1010);
    send_word(4'b1010, 1'b1, 1'b0, 1'b0);
    send_word(4'b0101, 1'b1, 1'b0, 1'b0);
    chk("overrun_pulse", 32'(overrun), 32'd1);
    chk("overrun_held_data", 32'(out_data), 32'(4'b1010));
    step(0, 0, 0, 0);
    chk("overrun_one_cycle", 32'(overrun), 32'd0);
    drain();

    // Transfer and load on the same edge: valid stays high with new data
    exp_q.push_back(4'b0011);
    send_word(4'b0011, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(4'b1100);
    send_word(4'b1100, 1'b1, 1'b1, 1'b0);
    chk("reload_valid", 32'(out_valid), 32'd1);
    chk("reload_data", 32'(out_data), 32'(4'b1100));
    drain();
    chk("overrun_total", 32'(ov_seen), 32'd1);

    // Reset mid-word with a held word: everything lost immediately
    send_word(4'b1001, 1'b1, 1'b0, 1'b0);
    step(1, 1, 1, 0); step(1, 0, 1, 0);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_valid", 32'(out_valid), 32'd0);
    chk("async_reset_data", 32'(out_data), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.push_back(4'b1111);
    send_word(4'b1111, 1'b1, 1'b0, 1'b0);
    chk("post_reset_valid", 32'(out_valid), 32'd1);
    drain();

    // Parity mismatch still delivers the word
    pe_seen = 0;
    exp_q.push_back(4'b1011);
    send_word(4'b1011, 1'b1, 1'b0, 1'b1);
    chk("parity_err_pulse", 32'(parity_err), PAR ? 32'd1 : 32'd0);
    drain();
    chk("parity_err_total", 32'(pe_seen), PAR ? 32'd1 : 32'd0);

    // Random words, both orders
    for (int k = 0; k < 6; k++) begin
      rw = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      rm = 1'($urandom_range(0, 1));
      exp_q.push_back(model(rw, rm));
      send_word(rw, rm, 1'b0, 1'b0);
      drain();
    end
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("no_parity_err_on_good_words", 32'(pe_seen), PAR ? 32'd1 : 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/shift_deser_rx.md
Name: shift_deser_rx

Overview:
- Serial-to-parallel receiver: the far end of the universal shift register's serial output path.
- Captures a framed serial bitstream (one bit per clock, qualified by an enable) and assembles WIDTH-bit words, LSB-first or MSB-first.
- Presents each completed word on a one-deep output holding register with a valid/ready handshake.
- Sits between the serial link from a shift-register transmitter and the parallel consumer logic.

Parameters:
- WIDTH, 4, data word width in bits (>=2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  bit-slot qualifier; sdata/sframe sampled only when en=1.
- sdata  input  1  serial data bit.
- sframe  input  1  start-of-word marker, coincident with the first bit of a word.
- msb_first  input  1  1: first bit received lands in out_data[WIDTH-1]; 0: first bit lands in out_data[0]. Sampled on the frame-start bit, held for the whole word.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  WIDTH  assembled word.
- out_valid  output  1  out_data holds an unconsumed word.
- frame_err  output  1  one-cycle pulse: sframe arrived mid-word.
- overrun  output  1  one-cycle pulse: completed word dropped because holding register full.
- parity_err  output  1  one-cycle pulse; see Optional Feature. Tied 0 when feature absent.

Behaviour:
- Reset (async, immediate): state IDLE, bit counter 0, shift register 0, out_data 0, out_valid 0, all pulse outputs 0.
- A word is FRAME_LEN bits: WIDTH, or WIDTH+1 with parity.
- IDLE state:
  - en=1 and sframe=1: capture sdata as bit 1 of FRAME_LEN, latch msb_first, counter=1, go to RECV.
  - sframe=1 with en=0: ignored.
  - Bits with sframe=0: ignored.
- RECV state:
  - Each en=1 cycle captures sdata and increments the counter.
  - en=0: counter, shift register and state hold.
  - msb_first=1: shift left, new bit enters at bit 0. msb_first=0: shift right, new bit enters at bit WIDTH-1.
- Completion (counter reaches FRAME_LEN): return to IDLE in the same edge.
  - Holding register empty, or out_ready=1 that cycle: out_data loaded with the word, out_valid=1 after that edge.
  - Latency: last bit sampled at edge N -> word visible after edge N.
- Handshake: transfer occurs when out_valid & out_ready at a rising edge.
  - out_valid falls after the transfer edge unless a new word loads on that same edge, in which case it stays 1 with new data.
  - out_data is stable while out_valid=1 and out_ready=0.
- Overrun: word completes while out_valid=1 and out_ready=0 -> new word discarded, held word kept, overrun=1 for one cycle.
- Resync: en=1 and sframe=1 while in RECV -> partial word discarded, frame_err=1 for one cycle, the current bit becomes bit 1 of a new word (counter=1, msb_first relatched).
- Back-to-back frames: sframe on the cycle after completion starts the next word with no gap cycle.
- Reset mid-word or with out_valid=1: all partial and held data lost.

Optional Feature:
- Macro: SHIFT_DESER_PARITY_CHECK_EN.
- Defined:
  - FRAME_LEN = WIDTH+1; the final bit is even parity over the WIDTH data bits and is not stored in out_data.
  - Mismatch: word still delivered (or dropped per overrun rule), and parity_err=1 for one cycle on the completion edge.
- Undefined: FRAME_LEN = WIDTH, no parity bit expected, parity_err constant 0.

Test Plan:
- WIDTH=4, msb_first=1, en=1, sframe on first bit, bits 1,0,1,1 -> out_data=4'b1011, out_valid=1 right after the 4th bit edge; out_ready=1 next cycle -> out_valid=0.
- Same bits, msb_first=0 -> out_data=4'b1101.
- msb_first=1, bits 1,0, then en=0 for 3 cycles with sdata/sframe toggling, then 1,1 -> out_data=4'b1011, no frame_err.
- Bits 1,1, then sframe with bits 0,1,1,0 -> frame_err single pulse at the resync edge; out_data=4'b0110 (msb_first=1).
- out_ready=0; words 1010 then 0101 back-to-back -> out_data stays 1010, overrun pulses at the second completion; out_ready=1 -> transfer, out_valid=0.
- Reset asserted after 2 of 4 bits -> outputs 0 immediately; frame 1111 after release -> out_data=4'b1111. With parity macro: data 1011 with parity bit 0 -> parity_err pulse and out_data=1011.
